// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encodings and port IDs.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_DONE   = 2'b10
    } arb_state_t;

    localparam logic ARB_PORT_C = 1'b0;
    localparam logic ARB_PORT_L = 1'b1;

endpackage

// File: rtl/dmem_arbiter_pick2.sv
// Two-requester winner selection: round-robin on `last`, or fixed CPU priority
// when DMEM_ARB_CPU_PRIO_EN is defined.
module arb_rr_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = ARB_PORT_C;
        if (req == 2'b11) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            winner = ARB_PORT_C;
`else
            winner = ~last;
`endif
        end else if (req[ARB_PORT_L]) begin
            winner = ARB_PORT_L;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the Data_Memory port between the CPU (C) and loader (L) as serialized
// multi-cycle transactions. DMEM_ARB_CPU_PRIO_EN selects fixed CPU priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_done,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_done,
    output logic [DW-1:0] l_rdata,
    output logic [AW-1:0] mem_access_addr,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_write_en,
    output logic          mem_read,
    input  logic [DW-1:0] mem_read_data,
    output logic          busy
);

    localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);

    arb_state_t    state_reg, state_next;
    logic [2:0]    cnt_reg, cnt_next;
    logic          last_reg;
    logic          win_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;

    logic          take;
    logic          cap;
    logic          pick_winner;
    logic          pick_valid;

    // Request fields gathered per port ID so the winner can index them.
    logic [1:0]    req_vec;
    logic [1:0]    we_vec;
    logic [AW-1:0] addr_vec  [2];
    logic [DW-1:0] wdata_vec [2];

    assign req_vec   = {l_req, c_req};
    assign we_vec    = {l_we, c_we};
    assign addr_vec[ARB_PORT_C]  = c_addr;
    assign addr_vec[ARB_PORT_L]  = l_addr;
    assign wdata_vec[ARB_PORT_C] = c_wdata;
    assign wdata_vec[ARB_PORT_L] = l_wdata;

    arb_rr_pick2 u_pick (
        .req    (req_vec),
        .last   (last_reg),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        take         = 1'b0;
        cap          = 1'b0;
        mem_write_en = 1'b0;
        mem_read     = 1'b0;
        c_done       = 1'b0;
        l_done       = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_valid) begin
                    take       = 1'b1;
                    cnt_next   = 3'd0;
                    state_next = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (we_reg) begin
                    mem_write_en = 1'b1;
                    state_next   = ARB_DONE;
                end else begin
                    mem_read = 1'b1;
                    if (cnt_reg == RD_LAST) begin
                        cap        = 1'b1;
                        cnt_next   = 3'd0;
                        state_next = ARB_DONE;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            ARB_DONE: begin
                c_done     = (win_reg == ARB_PORT_C);
                l_done     = (win_reg == ARB_PORT_L);
                state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Transaction is frozen at grant; later changes on the request port are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg   <= 3'd0;
            last_reg  <= ARB_PORT_C;
            win_reg   <= ARB_PORT_C;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
            if (take) begin
                last_reg  <= pick_winner;
                win_reg   <= pick_winner;
                we_reg    <= we_vec[pick_winner];
                addr_reg  <= addr_vec[pick_winner];
                wdata_reg <= wdata_vec[pick_winner];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic          gnt_reg;
            logic [DW-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    gnt_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    gnt_reg <= take && (pick_winner == 1'(gi));
                    if (cap && (win_reg == 1'(gi))) begin
                        rdata_reg <= mem_read_data;
                    end
                end
            end
        end
    endgenerate

    assign c_gnt           = g_port[0].gnt_reg;
    assign l_gnt           = g_port[1].gnt_reg;
    assign c_rdata         = g_port[0].rdata_reg;
    assign l_rdata         = g_port[1].rdata_reg;
    assign mem_access_addr = addr_reg;
    assign mem_write_data  = wdata_reg;
    assign busy            = (state_reg != ARB_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level schedule model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int RD_LAT = 3;
    localparam int MAXC   = 2048;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       c_req = 1'b0, c_we = 1'b0;
    logic [7:0] c_addr = 8'h00, c_wdata = 8'h00;
    logic       l_req = 1'b0, l_we = 1'b0;
    logic [7:0] l_addr = 8'h00, l_wdata = 8'h00;
    logic       c_gnt, c_done, l_gnt, l_done;
    logic [7:0] c_rdata, l_rdata;
    logic [7:0] mem_access_addr, mem_write_data, mem_read_data;
    logic       mem_write_en, mem_read, busy;

    always #5 clk = ~clk;

    dmem_arbiter #(.RD_LAT(RD_LAT), .AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Physical Data_Memory stand-in driven by the DUT.
    logic [7:0] mem [256];
    assign mem_read_data = mem[mem_access_addr];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h20] = 8'h3C;
        forever begin
            @(posedge clk);
            if (mem_write_en === 1'b1) mem[mem_access_addr] = mem_write_data;
        end
    end

    // Expected outputs per cycle; index k = cycle following edge k-1.
    bit         e_cg [MAXC], e_lg [MAXC], e_cd [MAXC], e_ld [MAXC];
    bit         e_we [MAXC], e_rd [MAXC], e_busy [MAXC], e_rst [MAXC];
    logic [7:0] e_addr [MAXC], e_wd [MAXC];
    bit         u_c [MAXC], u_l [MAXC];
    logic [7:0] u_cval [MAXC], u_lval [MAXC];

    logic [7:0] ref_mem [256];
    int         edge_n = 0;
    int         m_free = 0;
    bit         m_last = 1'b0;
    bit         mw, mwe;
    int         mlen;
    logic [7:0] ma, md;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        ref_mem[8'h20] = 8'h3C;
        forever begin
            @(posedge clk);
            edge_n++;
            if (edge_n + RD_LAT + 4 >= MAXC) begin
                // no room left to schedule
            end else if (!reset) begin
                for (int k = edge_n + 1; k < MAXC; k++) begin
                    e_cg[k] = 0; e_lg[k] = 0; e_cd[k] = 0; e_ld[k] = 0;
                    e_we[k] = 0; e_rd[k] = 0; e_busy[k] = 0; e_rst[k] = 0;
                    u_c[k] = 0; u_l[k] = 0;
                end
                e_rst[edge_n + 1] = 1;
                u_c[edge_n + 1] = 1; u_cval[edge_n + 1] = 8'h00;
                u_l[edge_n + 1] = 1; u_lval[edge_n + 1] = 8'h00;
                m_last = 1'b0;
                m_free = edge_n + 1;
            end else if (edge_n >= m_free && (c_req || l_req)) begin
                if (c_req && l_req) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                    mw = 1'b0;
`else
                    mw = ~m_last;
`endif
                end else begin
                    mw = l_req;
                end
                mwe  = mw ? l_we : c_we;
                ma   = mw ? l_addr : c_addr;
                md   = mw ? l_wdata : c_wdata;
                mlen = mwe ? 1 : RD_LAT;
                if (mw) e_lg[edge_n + 1] = 1; else e_cg[edge_n + 1] = 1;
                for (int k = 1; k <= mlen; k++) begin
                    e_we[edge_n + k] = mwe;
                    e_rd[edge_n + k] = !mwe;
                    e_addr[edge_n + k] = ma;
                    e_wd[edge_n + k] = md;
                end
                for (int k = 1; k <= mlen + 1; k++) e_busy[edge_n + k] = 1;
                if (mw) e_ld[edge_n + mlen + 1] = 1; else e_cd[edge_n + mlen + 1] = 1;
                if (mwe) begin
                    ref_mem[ma] = md;
                end else if (mw) begin
                    u_l[edge_n + mlen + 1] = 1; u_lval[edge_n + mlen + 1] = ref_mem[ma];
                end else begin
                    u_c[edge_n + mlen + 1] = 1; u_cval[edge_n + mlen + 1] = ref_mem[ma];
                end
                m_free = edge_n + mlen + 2;
                m_last = mw;
            end
        end
    end

    // Per-cycle compare plus event monitors for the directed scenarios.
    logic [7:0] cur_c = 8'h00, cur_l = 8'h00;
    int         wr_cnt = 0, rd_cnt = 0, done_cnt = 0, ldone_cnt = 0;
    logic [7:0] last_addr = 8'h00;
    bit         grant_q [$];

    initial begin
        int k;
        forever begin
            @(negedge clk);
            k = edge_n + 1;
            if (edge_n > 0 && k < MAXC) begin
                if (u_c[k]) cur_c = u_cval[k];
                if (u_l[k]) cur_l = u_lval[k];
                chk($sformatf("c_gnt@%0d", k), c_gnt, e_cg[k]);
                chk($sformatf("l_gnt@%0d", k), l_gnt, e_lg[k]);
                chk($sformatf("c_done@%0d", k), c_done, e_cd[k]);
                chk($sformatf("l_done@%0d", k), l_done, e_ld[k]);
                chk($sformatf("mem_write_en@%0d", k), mem_write_en, e_we[k]);
                chk($sformatf("mem_read@%0d", k), mem_read, e_rd[k]);
                chk($sformatf("busy@%0d", k), busy, e_busy[k]);
                chk($sformatf("c_rdata@%0d", k), c_rdata, cur_c);
                chk($sformatf("l_rdata@%0d", k), l_rdata, cur_l);
                if (e_we[k] || e_rd[k])
                    chk($sformatf("mem_addr@%0d", k), mem_access_addr, e_addr[k]);
                if (e_we[k])
                    chk($sformatf("mem_wdata@%0d", k), mem_write_data, e_wd[k]);
                if (e_rst[k]) begin
                    chk($sformatf("rst_addr@%0d", k), mem_access_addr, 8'h00);
                    chk($sformatf("rst_wdata@%0d", k), mem_write_data, 8'h00);
                end
            end
            if (c_gnt === 1'b1) grant_q.push_back(1'b0);
            if (l_gnt === 1'b1) grant_q.push_back(1'b1);
            if (mem_write_en === 1'b1) begin wr_cnt++; last_addr = mem_access_addr; end
            if (mem_read === 1'b1) begin rd_cnt++; last_addr = mem_access_addr; end
            if (c_done === 1'b1 || l_done === 1'b1) done_cnt++;
            if (l_done === 1'b1) ldone_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        c_req = 1'b0;
        l_req = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    task automatic txn(input bit port, input bit we, input logic [7:0] a,
                       input logic [7:0] d, output int lat);
        bit seen = 0;
        step();
        if (port) begin
            l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d;
        end
        lat = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            lat++;
            seen = port ? (l_done === 1'b1) : (c_done === 1'b1);
        end
        if (!seen) chk("txn_timeout", 32'd0, 32'd1);
        if (port) l_req = 1'b0; else c_req = 1'b0;
    endtask

    int  lat;
    bit  seen;

    initial begin
        // Scenario 1: store then load on the CPU port.
        do_reset();
        wr_cnt = 0;
        txn(1'b0, 1'b1, 8'h10, 8'hA5, lat);
        chk("store_latency", lat, 2);
        chk("store_we_cycles", wr_cnt, 1);
        chk("store_addr", last_addr, 8'h10);
        txn(1'b0, 1'b0, 8'h10, 8'h00, lat);
        chk("load_latency", lat, 4);
        chk("load_c_rdata", c_rdata, 8'hA5);

        // Scenario 2: loader read with 3-cycle read latency.
        rd_cnt = 0;
        txn(1'b1, 1'b0, 8'h20, 8'h00, lat);
        chk("l_load_latency", lat, 4);
        chk("l_read_cycles", rd_cnt, 3);
        chk("l_rdata", l_rdata, 8'h3C);
        chk("c_rdata_kept", c_rdata, 8'hA5);

        // Loader store observed by a later CPU load.
        txn(1'b1, 1'b1, 8'h30, 8'h77, lat);
        chk("l_store_latency", lat, 2);
        txn(1'b0, 1'b0, 8'h30, 8'h00, lat);
        chk("c_load_after_l_store", c_rdata, 8'h77);

        // Scenario 3: address change after grant is ignored.
        step();
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin step(); seen = (c_gnt === 1'b1); end
        if (!seen) chk("gnt_timeout", 32'd0, 32'd1);
        c_addr = 8'h11;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin step(); seen = (c_done === 1'b1); end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        c_req = 1'b0;
        chk("latched_addr", last_addr, 8'h10);
        chk("latched_rdata", c_rdata, 8'hA5);

        // Scenario 4: both ports requesting continuously after reset.
        do_reset();
        grant_q.delete();
        done_cnt = 0;
        c_we = 1'b0; c_addr = 8'h40;
        l_we = 1'b0; l_addr = 8'h41;
        c_req = 1'b1; l_req = 1'b1;
        for (int i = 0; i < 60 && done_cnt < 4; i++) step();
        c_req = 1'b0; l_req = 1'b0;
        chk("rr_done_count", done_cnt, 4);
        repeat (4) step();
        chk("rr_grant_count", grant_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            chk($sformatf("grant_order[%0d]", i), (i < grant_q.size()) ? grant_q[i] : 1'bx, 1'b0);
`else
            chk($sformatf("grant_order[%0d]", i), (i < grant_q.size()) ? grant_q[i] : 1'bx, (i % 2 == 0));
`endif
        end

        // Scenario 5: reset in the second ACCESS cycle of a read.
        step();
        l_req = 1'b1; l_we = 1'b0; l_addr = 8'h20;
        rd_cnt = 0; ldone_cnt = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin step(); seen = (l_gnt === 1'b1); end
        if (!seen) chk("abort_gnt_timeout", 32'd0, 32'd1);
        step();
        reset = 1'b0;
        l_req = 1'b0;
        step();
        chk("abort_busy", busy, 1'b0);
        chk("abort_mem_read", mem_read, 1'b0);
        chk("abort_l_rdata", l_rdata, 8'h00);
        reset = 1'b1;
        repeat (4) step();
        chk("abort_read_cycles", rd_cnt, 2);
        chk("abort_no_done", ldone_cnt, 0);
        chk("abort_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
